// File: rtl/rggen_register_access_initiator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rggen_register_access_initiator
// Function : Issues one host request at a time as a register access, with timeout.
// Revision : 1.0
//------------------------------------------------------------------------------
module rggen_register_access_initiator #(
    parameter int ADDRESS_WIDTH  = 16,
    parameter int BUS_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_host_valid,
    output logic                     o_host_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_host_address,
    input  logic                     i_host_write,
    input  logic [BUS_WIDTH-1:0]     i_host_write_data,
    input  logic [BUS_WIDTH/8-1:0]   i_host_strobe,
    output logic                     o_host_resp_valid,
    input  logic                     i_host_resp_ready,
    output logic [1:0]               o_host_resp_status,
    output logic [BUS_WIDTH-1:0]     o_host_read_data,
    output logic                     o_reg_valid,
    output logic [ADDRESS_WIDTH-1:0] o_reg_address,
    output logic                     o_reg_write,
    output logic [BUS_WIDTH-1:0]     o_reg_write_data,
    output logic [BUS_WIDTH-1:0]     o_reg_write_mask,
    input  logic                     i_reg_ready,
    input  logic [1:0]               i_reg_status,
    input  logic [BUS_WIDTH-1:0]     i_reg_read_data
);

    localparam int c_STROBE_WIDTH = BUS_WIDTH / 8;
    localparam int c_LANE_BITS    = (c_STROBE_WIDTH > 1) ? $clog2(c_STROBE_WIDTH) : 0;
    localparam logic [ADDRESS_WIDTH-1:0] c_LANE_MASK = ADDRESS_WIDTH'((1 << c_LANE_BITS) - 1);
    localparam bit c_TIMEOUT_ENABLE  = (TIMEOUT_CYCLES > 0);
    localparam int c_COUNT_WIDTH     = c_TIMEOUT_ENABLE ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_TIMEOUT_LAST_INT = c_TIMEOUT_ENABLE ? (TIMEOUT_CYCLES - 1) : 0;
    localparam logic [c_COUNT_WIDTH-1:0] c_TIMEOUT_LAST = c_COUNT_WIDTH'(c_TIMEOUT_LAST_INT);
    localparam logic [1:0] c_STATUS_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_RESPONSE = 2'd2
    } state_e;

    state_e                     r_state;
    state_e                     w_state_next;
    logic                       w_accept;
    logic                       w_complete;
    logic                       w_timeout;
    logic [c_COUNT_WIDTH-1:0]   r_count;
    logic [ADDRESS_WIDTH-1:0]   r_address;
    logic                       r_write;
    logic [BUS_WIDTH-1:0]       r_write_data;
    logic [BUS_WIDTH-1:0]       r_write_mask;
    logic [BUS_WIDTH-1:0]       w_write_mask;
    logic [1:0]                 r_resp_status;
    logic [BUS_WIDTH-1:0]       r_read_data;

    generate
        for (genvar i = 0; i < c_STROBE_WIDTH; i++) begin : g_mask
            assign w_write_mask[8*i+:8] = {8{i_host_strobe[i]}};
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_accept          = 1'b0;
        w_complete        = 1'b0;
        w_timeout         = 1'b0;
        o_host_ready      = 1'b0;
        o_reg_valid       = 1'b0;
        o_host_resp_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_host_ready = ~i_rst;
                w_accept     = i_host_valid & ~i_rst;
                if (w_accept) begin
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                o_reg_valid = 1'b1;
                // A ready arriving on the expiry cycle still counts as a normal completion.
                if (i_reg_ready) begin
                    w_complete   = 1'b1;
                    w_state_next = ST_RESPONSE;
                end else if (c_TIMEOUT_ENABLE && (r_count == c_TIMEOUT_LAST)) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_RESPONSE;
                end
            end
            ST_RESPONSE: begin
                o_host_resp_valid = 1'b1;
                if (i_host_resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if (c_TIMEOUT_ENABLE && (r_state == ST_ACCESS) && !i_reg_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_address    <= '0;
            r_write      <= 1'b0;
            r_write_data <= '0;
            r_write_mask <= '0;
        end else if (w_accept) begin
            r_address    <= i_host_address & ~c_LANE_MASK;
            r_write      <= i_host_write;
            r_write_data <= i_host_write_data;
            r_write_mask <= w_write_mask;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_resp_status <= 2'b00;
            r_read_data   <= '0;
        end else if (w_complete) begin
            r_resp_status <= i_reg_status;
            r_read_data   <= r_write ? '0 : i_reg_read_data;
        end else if (w_timeout) begin
            r_resp_status <= c_STATUS_SLVERR;
            r_read_data   <= '0;
        end
    end

    assign o_reg_address      = r_address;
    assign o_reg_write        = r_write;
    assign o_reg_write_data   = r_write_data;
    assign o_reg_write_mask   = r_write_mask;
    assign o_host_resp_status = r_resp_status;
    assign o_host_read_data   = r_read_data;

endmodule
`default_nettype wire

// File: tb/tb_rggen_register_access_initiator.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_rggen_register_access_initiator
// Function : Directed self-checking bench for the register access initiator.
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_rggen_register_access_initiator;

    logic        clk;
    logic        i_rst;
    logic        i_host_valid;
    logic        o_host_ready;
    logic [15:0] i_host_address;
    logic        i_host_write;
    logic [31:0] i_host_write_data;
    logic [3:0]  i_host_strobe;
    logic        o_host_resp_valid;
    logic        i_host_resp_ready;
    logic [1:0]  o_host_resp_status;
    logic [31:0] o_host_read_data;
    logic        o_reg_valid;
    logic [15:0] o_reg_address;
    logic        o_reg_write;
    logic [31:0] o_reg_write_data;
    logic [31:0] o_reg_write_mask;
    logic        i_reg_ready;
    logic [1:0]  i_reg_status;
    logic [31:0] i_reg_read_data;

    int check_count = 0;
    int error_count = 0;
    int valid_cycles;

    rggen_register_access_initiator #(
        .ADDRESS_WIDTH  (16),
        .BUS_WIDTH      (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .i_clk              (clk),
        .i_rst              (i_rst),
        .i_host_valid       (i_host_valid),
        .o_host_ready       (o_host_ready),
        .i_host_address     (i_host_address),
        .i_host_write       (i_host_write),
        .i_host_write_data  (i_host_write_data),
        .i_host_strobe      (i_host_strobe),
        .o_host_resp_valid  (o_host_resp_valid),
        .i_host_resp_ready  (i_host_resp_ready),
        .o_host_resp_status (o_host_resp_status),
        .o_host_read_data   (o_host_read_data),
        .o_reg_valid        (o_reg_valid),
        .o_reg_address      (o_reg_address),
        .o_reg_write        (o_reg_write),
        .o_reg_write_data   (o_reg_write_data),
        .o_reg_write_mask   (o_reg_write_mask),
        .i_reg_ready        (i_reg_ready),
        .i_reg_status       (i_reg_status),
        .i_reg_read_data    (i_reg_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Called on a falling edge in IDLE; returns on the falling edge after acceptance.
    task automatic send_request(input logic [15:0] addr, input logic wr,
                                input logic [31:0] data, input logic [3:0] strb);
        i_host_valid      = 1'b1;
        i_host_address    = addr;
        i_host_write      = wr;
        i_host_write_data = data;
        i_host_strobe     = strb;
        check_value("host_ready_idle", {63'd0, o_host_ready}, 64'd1);
        @(negedge clk);
        i_host_valid = 1'b0;
    endtask

    // Responder: asserts ready on the (ready_after+1)-th valid cycle; -1 never answers.
    task automatic respond(input int ready_after, input logic [1:0] status,
                           input logic [31:0] rdata, output int cycles);
        cycles = 0;
        for (int c = 0; c < 20; c++) begin
            if (!o_reg_valid) break;
            cycles++;
            i_reg_ready     = (ready_after >= 0) && (cycles == ready_after + 1);
            i_reg_status    = status;
            i_reg_read_data = rdata;
            @(negedge clk);
        end
        i_reg_ready = 1'b0;
    endtask

    task automatic finish_response;
        i_host_resp_ready = 1'b1;
        @(negedge clk);
        i_host_resp_ready = 1'b0;
        check_value("resp_valid_cleared", {63'd0, o_host_resp_valid}, 64'd0);
        check_value("host_ready_after_resp", {63'd0, o_host_ready}, 64'd1);
    endtask

    initial begin
        i_rst = 1'b1;
        i_host_valid = 1'b0;
        i_host_address = '0;
        i_host_write = 1'b0;
        i_host_write_data = '0;
        i_host_strobe = '0;
        i_host_resp_ready = 1'b0;
        i_reg_ready = 1'b0;
        i_reg_status = 2'b00;
        i_reg_read_data = '0;

        repeat (2) @(negedge clk);
        check_value("rst_host_ready", {63'd0, o_host_ready}, 64'd0);
        check_value("rst_reg_valid", {63'd0, o_reg_valid}, 64'd0);
        check_value("rst_resp_valid", {63'd0, o_host_resp_valid}, 64'd0);
        check_value("rst_reg_address", {48'd0, o_reg_address}, 64'd0);
        check_value("rst_write_mask", {32'd0, o_reg_write_mask}, 64'd0);
        i_rst = 1'b0;
        @(negedge clk);

        // Write with lower two byte lanes enabled; responder data must not leak through.
        send_request(16'h0010, 1'b1, 32'hA5A5_1234, 4'b0011);
        check_value("wr_reg_valid", {63'd0, o_reg_valid}, 64'd1);
        check_value("wr_host_ready", {63'd0, o_host_ready}, 64'd0);
        check_value("wr_reg_address", {48'd0, o_reg_address}, 64'h0010);
        check_value("wr_reg_write", {63'd0, o_reg_write}, 64'd1);
        check_value("wr_write_data", {32'd0, o_reg_write_data}, 64'hA5A5_1234);
        check_value("wr_write_mask", {32'd0, o_reg_write_mask}, 64'h0000_FFFF);
        respond(0, 2'b00, 32'h1234_5678, valid_cycles);
        check_value("wr_valid_cycles", valid_cycles, 1);
        check_value("wr_resp_valid", {63'd0, o_host_resp_valid}, 64'd1);
        check_value("wr_resp_status", {62'd0, o_host_resp_status}, 64'd0);
        check_value("wr_read_data", {32'd0, o_host_read_data}, 64'd0);
        finish_response();

        // Read from an unaligned address; ready lands on the expiry cycle and must win.
        send_request(16'h0013, 1'b0, 32'h0, 4'b1111);
        check_value("rd_reg_address", {48'd0, o_reg_address}, 64'h0010);
        check_value("rd_reg_write", {63'd0, o_reg_write}, 64'd0);
        respond(3, 2'b00, 32'hDEAD_BEEF, valid_cycles);
        check_value("rd_valid_cycles", valid_cycles, 4);
        check_value("rd_resp_status", {62'd0, o_host_resp_status}, 64'd0);
        check_value("rd_read_data", {32'd0, o_host_read_data}, 64'hDEAD_BEEF);
        finish_response();

        // Responder never answers: four valid cycles then SLVERR with zero data.
        send_request(16'h0040, 1'b0, 32'h0, 4'b1111);
        respond(-1, 2'b00, 32'hFFFF_FFFF, valid_cycles);
        check_value("to_valid_cycles", valid_cycles, 4);
        check_value("to_resp_valid", {63'd0, o_host_resp_valid}, 64'd1);
        check_value("to_resp_status", {62'd0, o_host_resp_status}, 64'h2);
        check_value("to_read_data", {32'd0, o_host_read_data}, 64'd0);
        finish_response();

        // Response backpressure with a pending host request and a stray responder ready.
        send_request(16'h0008, 1'b0, 32'h0, 4'b1111);
        respond(0, 2'b00, 32'h0BAD_F00D, valid_cycles);
        i_host_valid   = 1'b1;
        i_host_address = 16'h0020;
        i_host_write   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i_reg_ready     = 1'b1;
            i_reg_status    = 2'b11;
            i_reg_read_data = 32'h1111_1111;
            check_value("bp_resp_valid", {63'd0, o_host_resp_valid}, 64'd1);
            check_value("bp_host_ready", {63'd0, o_host_ready}, 64'd0);
            check_value("bp_reg_valid", {63'd0, o_reg_valid}, 64'd0);
            check_value("bp_read_data", {32'd0, o_host_read_data}, 64'h0BAD_F00D);
            check_value("bp_resp_status", {62'd0, o_host_resp_status}, 64'd0);
            @(negedge clk);
        end
        i_reg_ready       = 1'b0;
        i_host_resp_ready = 1'b1;
        @(negedge clk);
        i_host_resp_ready = 1'b0;
        i_host_valid      = 1'b0;
        check_value("bp_host_ready_after", {63'd0, o_host_ready}, 64'd1);
        check_value("bp_reg_valid_after", {63'd0, o_reg_valid}, 64'd0);
        @(negedge clk);

        // Decode error on a read: status and sampled data forwarded.
        send_request(16'h00F0, 1'b0, 32'h0, 4'b1111);
        respond(1, 2'b11, 32'hCAFE_F00D, valid_cycles);
        check_value("de_valid_cycles", valid_cycles, 2);
        check_value("de_resp_status", {62'd0, o_host_resp_status}, 64'h3);
        check_value("de_read_data", {32'd0, o_host_read_data}, 64'hCAFE_F00D);
        finish_response();

        // Reset in the middle of an access, then a normal write.
        send_request(16'h0030, 1'b0, 32'h0, 4'b1111);
        check_value("ra_reg_valid_before", {63'd0, o_reg_valid}, 64'd1);
        i_rst = 1'b1;
        #1;
        check_value("ra_reg_valid", {63'd0, o_reg_valid}, 64'd0);
        check_value("ra_resp_valid", {63'd0, o_host_resp_valid}, 64'd0);
        check_value("ra_host_ready", {63'd0, o_host_ready}, 64'd0);
        @(negedge clk);
        i_rst = 1'b0;
        @(negedge clk);
        check_value("ra_resp_valid_after", {63'd0, o_host_resp_valid}, 64'd0);
        send_request(16'h0024, 1'b1, 32'h0102_0304, 4'b1100);
        check_value("ra_reg_address", {48'd0, o_reg_address}, 64'h0024);
        check_value("ra_write_mask", {32'd0, o_reg_write_mask}, 64'hFFFF_0000);
        respond(0, 2'b00, 32'h0, valid_cycles);
        check_value("ra_valid_cycles", valid_cycles, 1);
        check_value("ra_resp_status", {62'd0, o_host_resp_status}, 64'd0);
        check_value("ra_read_data", {32'd0, o_host_read_data}, 64'd0);
        finish_response();

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
`default_nettype wire
